// File: rtl/iexecute.sv
// Execute stage of a five-stage LEGv8-style pipeline.
// Selects ALU operands, decodes the ALU operation, computes the branch target
// and taken flag, and registers everything into the EX/MEM boundary.
module iexecute #(
  parameter int WORD = 64,
  parameter int OPW  = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic [WORD-1:0] cur_pc,
  input  logic [OPW-1:0]  opcode,
  input  logic [WORD-1:0] read_data1,
  input  logic [WORD-1:0] read_data2,
  input  logic [WORD-1:0] sign_extended_output,
  input  logic [4:0]      rd,
  input  logic [1:0]      alu_op,
  input  logic            alu_src,
  input  logic            branch,
  input  logic            uncondbranch,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  output logic            ex_valid,
  output logic [WORD-1:0] alu_result,
  output logic            zero,
  output logic [WORD-1:0] branch_target,
  output logic            pc_src,
  output logic [WORD-1:0] store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_reg_write,
  output logic            illegal
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(11'b10001011000);
  localparam logic [OPW-1:0] OP_SUB = OPW'(11'b11001011000);
  localparam logic [OPW-1:0] OP_AND = OPW'(11'b10001010000);
  localparam logic [OPW-1:0] OP_ORR = OPW'(11'b10101010000);

  logic [WORD-1:0] operand_b;
  logic [WORD-1:0] alu_next;
  logic            bad_op;
  logic            zero_next;
  logic [WORD-1:0] target_next;
  logic            taken_next;

  // ALU: operand select, operation decode, and the illegal-opcode flag.
  // alu_op 11 has no meaning of its own and falls into the ADD default.
  always_comb begin
    operand_b = alu_src ? sign_extended_output : read_data2;
    alu_next  = read_data1 + operand_b;
    bad_op    = 1'b0;
    case (alu_op)
      2'b01: alu_next = operand_b;
      2'b10: begin
        case (opcode)
          OP_ADD:  alu_next = read_data1 + operand_b;
          OP_SUB:  alu_next = read_data1 - operand_b;
          OP_AND:  alu_next = read_data1 & operand_b;
          OP_ORR:  alu_next = read_data1 | operand_b;
          default: begin
            alu_next = '0;
            bad_op   = 1'b1;
          end
        endcase
      end
      default: alu_next = read_data1 + operand_b;
    endcase
  end

  // Branch resolution; a left shift of a two's complement word keeps its
  // sign modulo 2^WORD, so a plain add gives backward branches for free.
  always_comb begin
    zero_next   = (alu_next == '0);
    target_next = cur_pc + (sign_extended_output << 2);
    taken_next  = !bad_op && (uncondbranch || (branch && zero_next));
  end

  // EX/MEM register: flush beats stall, stall holds, an invalid slot becomes
  // a bubble, and an illegal instruction keeps ex_valid but loses its effects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      alu_result    <= '0;
      zero          <= 1'b0;
      branch_target <= '0;
      pc_src        <= 1'b0;
      store_data    <= '0;
      ex_rd         <= '0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      illegal       <= 1'b0;
    end else if (flush || !stall) begin
      if (flush || !in_valid) begin
        ex_valid      <= 1'b0;
        alu_result    <= '0;
        zero          <= 1'b0;
        branch_target <= '0;
        pc_src        <= 1'b0;
        store_data    <= '0;
        ex_rd         <= '0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_reg_write  <= 1'b0;
        illegal       <= 1'b0;
      end else begin
        ex_valid      <= 1'b1;
        alu_result    <= alu_next;
        zero          <= zero_next;
        branch_target <= target_next;
        pc_src        <= taken_next;
        store_data    <= read_data2;
        ex_rd         <= rd;
        ex_mem_read   <= mem_read && !bad_op;
        ex_mem_write  <= mem_write && !bad_op;
        ex_mem_to_reg <= mem_to_reg;
        ex_reg_write  <= reg_write && !bad_op;
        illegal       <= bad_op;
      end
    end
  end

endmodule

// File: tb/tb_iexecute.sv
// Self-checking bench for iexecute: directed LEGv8 scenarios plus a
// randomized run checked against an instruction-level reference model.
module tb_iexecute;

  logic        clk;
  logic        reset;
  logic        in_valid, stall, flush;
  logic [63:0] cur_pc, read_data1, read_data2, sign_extended_output;
  logic [10:0] opcode;
  logic [4:0]  rd;
  logic [1:0]  alu_op;
  logic        alu_src, branch, uncondbranch, mem_read, mem_write, mem_to_reg, reg_write;
  logic        ex_valid, zero, pc_src, illegal;
  logic [63:0] alu_result, branch_target, store_data;
  logic [4:0]  ex_rd;
  logic        ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;

  int errors = 0;
  int checks = 0;

  localparam logic [10:0] ADD_OP = 11'b10001011000;
  localparam logic [10:0] SUB_OP = 11'b11001011000;
  localparam logic [10:0] AND_OP = 11'b10001010000;
  localparam logic [10:0] ORR_OP = 11'b10101010000;

  logic [204:0] obs;
  assign obs = {ex_valid, alu_result, zero, branch_target, pc_src, store_data, ex_rd,
                ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, illegal};

  iexecute #(.WORD(64), .OPW(11)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .cur_pc(cur_pc), .opcode(opcode), .read_data1(read_data1), .read_data2(read_data2),
    .sign_extended_output(sign_extended_output), .rd(rd), .alu_op(alu_op),
    .alu_src(alu_src), .branch(branch), .uncondbranch(uncondbranch),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .ex_valid(ex_valid), .alu_result(alu_result), .zero(zero),
    .branch_target(branch_target), .pc_src(pc_src), .store_data(store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction-level reference: what one valid instruction should leave in
  // the EX/MEM register, packed in the same field order as obs.
  function automatic logic [204:0] model();
    logic [63:0] a, b, r, tgt;
    logic        ill, taken, mr, mw, rw;
    a   = read_data1;
    b   = alu_src ? sign_extended_output : read_data2;
    ill = 1'b0;
    if (alu_op == 2'b01) r = b;
    else if (alu_op == 2'b10) begin
      if (opcode == ADD_OP)      r = a + b;
      else if (opcode == SUB_OP) r = a - b;
      else if (opcode == AND_OP) r = a & b;
      else if (opcode == ORR_OP) r = a | b;
      else begin r = 64'd0; ill = 1'b1; end
    end else r = a + b;
    tgt   = cur_pc + sign_extended_output * 64'd4;
    taken = uncondbranch || (branch && (r == 64'd0));
    mr = mem_read; mw = mem_write; rw = reg_write;
    if (ill) begin taken = 1'b0; mr = 1'b0; mw = 1'b0; rw = 1'b0; end
    return {1'b1, r, (r == 64'd0), tgt, taken, read_data2, rd, mr, mw, mem_to_reg, rw, ill};
  endfunction

  task automatic clear_inputs();
    in_valid = 0; stall = 0; flush = 0; cur_pc = 0; opcode = 0;
    read_data1 = 0; read_data2 = 0; sign_extended_output = 0; rd = 0;
    alu_op = 0; alu_src = 0; branch = 0; uncondbranch = 0;
    mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_write = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [204:0] exp;
    clear_inputs();
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 205'd0) begin errors++; $display("[TB] FAIL reset_initial got=%h want=0", obs); end
    in_valid = 1; read_data1 = 64'h10; read_data2 = 64'h20; rd = 5'd3; reg_write = 1;
    step();
    checks++;
    if (obs !== 205'd0) begin errors++; $display("[TB] FAIL reset_override got=%h want=0", obs); end
    reset = 1'b1;
    exp = model();
    step();
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL first_capture got=%h want=%h", obs, exp); end
  endtask

  task automatic test_load();
    clear_inputs();
    in_valid = 1; read_data1 = 64'h100; sign_extended_output = 64'd64; alu_src = 1;
    alu_op = 2'b00; rd = 5'd9; mem_read = 1; mem_to_reg = 1; reg_write = 1;
    step();
    checks++;
    if (alu_result !== 64'h140 || ex_mem_read !== 1'b1 || ex_reg_write !== 1'b1 ||
        ex_rd !== 5'd9 || pc_src !== 1'b0 || ex_valid !== 1'b1)
    begin
      errors++;
      $display("[TB] FAIL ldur got res=%h mr=%b rw=%b rd=%0d pc_src=%b v=%b want res=140 mr=1 rw=1 rd=9 pc_src=0 v=1",
               alu_result, ex_mem_read, ex_reg_write, ex_rd, pc_src, ex_valid);
    end
  endtask

  task automatic test_rtype();
    clear_inputs();
    in_valid = 1; alu_op = 2'b10; opcode = SUB_OP; read_data1 = 64'd5; read_data2 = 64'd7; reg_write = 1;
    step();
    checks++;
    if (alu_result !== 64'hFFFF_FFFF_FFFF_FFFE || zero !== 1'b0)
    begin errors++; $display("[TB] FAIL sub got res=%h zero=%b want res=fffffffffffffffe zero=0", alu_result, zero); end
    opcode = ADD_OP; read_data1 = 64'hFFFF_FFFF_FFFF_FFFF; read_data2 = 64'd1;
    step();
    checks++;
    if (alu_result !== 64'd0 || zero !== 1'b1)
    begin errors++; $display("[TB] FAIL add_wrap got res=%h zero=%b want res=0 zero=1", alu_result, zero); end
    opcode = AND_OP; read_data1 = 64'hF0F0; read_data2 = 64'h3CFF;
    step();
    checks++;
    if (alu_result !== 64'h30F0) begin errors++; $display("[TB] FAIL and got=%h want=30f0", alu_result); end
    opcode = ORR_OP;
    step();
    checks++;
    if (alu_result !== 64'hFCFF) begin errors++; $display("[TB] FAIL orr got=%h want=fcff", alu_result); end
  endtask

  task automatic test_branch();
    clear_inputs();
    in_valid = 1; cur_pc = 64'h20; sign_extended_output = 64'hFFFF_FFFF_FFFF_FFFB;
    read_data2 = 64'd0; alu_op = 2'b01; branch = 1; rd = 5'd11;
    step();
    checks++;
    if (pc_src !== 1'b1 || branch_target !== 64'h0C)
    begin errors++; $display("[TB] FAIL cbz_taken got pc_src=%b tgt=%h want pc_src=1 tgt=c", pc_src, branch_target); end
    read_data2 = 64'd3;
    step();
    checks++;
    if (pc_src !== 1'b0 || branch_target !== 64'h0C)
    begin errors++; $display("[TB] FAIL cbz_not_taken got pc_src=%b tgt=%h want pc_src=0 tgt=c", pc_src, branch_target); end
    clear_inputs();
    in_valid = 1; cur_pc = 64'h1C; sign_extended_output = 64'd64; uncondbranch = 1; read_data1 = 64'd9;
    step();
    checks++;
    if (pc_src !== 1'b1 || branch_target !== 64'h11C)
    begin errors++; $display("[TB] FAIL b_uncond got pc_src=%b tgt=%h want pc_src=1 tgt=11c", pc_src, branch_target); end
  endtask

  task automatic test_stall();
    logic [204:0] held;
    clear_inputs();
    in_valid = 1; alu_op = 2'b10; opcode = ADD_OP; read_data1 = 64'h1234; read_data2 = 64'h1111;
    rd = 5'd17; reg_write = 1; cur_pc = 64'h400; sign_extended_output = 64'd3;
    held = model();
    step();
    checks++;
    if (obs !== held) begin errors++; $display("[TB] FAIL stall_setup got=%h want=%h", obs, held); end
    for (int i = 0; i < 3; i++) begin
      stall = 1; opcode = SUB_OP; read_data1 = {$urandom, $urandom}; rd = 5'(i + 1); cur_pc = {$urandom, $urandom};
      in_valid = i[0];
      step();
      checks++;
      if (obs !== held) begin errors++; $display("[TB] FAIL stall_hold_%0d got=%h want=%h", i, obs, held); end
    end
    stall = 1; flush = 1; in_valid = 1;
    step();
    checks++;
    if (obs !== 205'd0) begin errors++; $display("[TB] FAIL stall_flush got=%h want=0", obs); end
    clear_inputs();
    in_valid = 1; read_data1 = 64'd1; rd = 5'd2; reg_write = 1;
    step();
    in_valid = 0; read_data1 = 64'd7;
    step();
    checks++;
    if (obs !== 205'd0) begin errors++; $display("[TB] FAIL invalid_bubble got=%h want=0", obs); end
  endtask

  task automatic test_illegal();
    clear_inputs();
    in_valid = 1; alu_op = 2'b10; opcode = 11'b11111111111; reg_write = 1; mem_write = 1;
    mem_read = 1; uncondbranch = 1; read_data1 = 64'h55; read_data2 = 64'h66; rd = 5'd4;
    step();
    checks++;
    if (illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_valid !== 1'b1 || pc_src !== 1'b0 ||
        ex_mem_write !== 1'b0 || ex_mem_read !== 1'b0 || alu_result !== 64'd0)
    begin
      errors++;
      $display("[TB] FAIL illegal got ill=%b rw=%b v=%b pc_src=%b mw=%b mr=%b res=%h want ill=1 rw=0 v=1 pc_src=0 mw=0 mr=0 res=0",
               illegal, ex_reg_write, ex_valid, pc_src, ex_mem_write, ex_mem_read, alu_result);
    end
  endtask

  task automatic test_async_reset();
    logic [204:0] exp;
    clear_inputs();
    in_valid = 1; read_data1 = 64'h80; read_data2 = 64'h8; rd = 5'd12; reg_write = 1;
    step();
    checks++;
    if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL async_setup got v=%b want 1", ex_valid); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 205'd0) begin errors++; $display("[TB] FAIL async_clear got=%h want=0", obs); end
    step();
    #3 reset = 1'b1;
    exp = model();
    step();
    checks++;
    if (obs !== exp) begin errors++; $display("[TB] FAIL async_resume got=%h want=%h", obs, exp); end
    stall = 1;
    step();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    step();
    checks++;
    if (obs !== 205'd0) begin errors++; $display("[TB] FAIL reset_mid_stall got=%h want=0", obs); end
  endtask

  task automatic test_random();
    logic [204:0] exp, nxt;
    logic [10:0]  ops [5];
    ops[0] = ADD_OP; ops[1] = SUB_OP; ops[2] = AND_OP; ops[3] = ORR_OP; ops[4] = 11'b0;
    exp = 205'd0;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 9) != 0);
      stall    = (i != 0) && ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      cur_pc   = {$urandom, $urandom};
      ops[4]   = 11'($urandom);
      opcode   = ops[$urandom_range(0, 4)];
      read_data1 = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: read_data2 = read_data1;
        1: read_data2 = 64'd0;
        default: read_data2 = {$urandom, $urandom};
      endcase
      sign_extended_output = {{40{1'b0}}, 24'($urandom)} - 64'h80_0000;
      rd = 5'($urandom); alu_op = 2'($urandom); alu_src = 1'($urandom);
      branch = 1'($urandom); uncondbranch = ($urandom_range(0, 3) == 0);
      mem_read = 1'($urandom); mem_write = 1'($urandom);
      mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
      if (flush)          nxt = 205'd0;
      else if (stall)     nxt = exp;
      else if (!in_valid) nxt = 205'd0;
      else                nxt = model();
      step();
      checks++;
      if (obs !== nxt) begin errors++; $display("[TB] FAIL random_%0d got=%h want=%h", i, obs, nxt); end
      exp = nxt;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_rtype();
    test_branch();
    test_stall();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
